// File: rtl/store_unit.sv
// store_unit: aligns one core store onto the 32-bit data bus and issues it with a valid/ready handshake.
// Build option `STORE_UNIT_MISALIGNED_SPLIT_EN: word-crossing stores become two beats instead of an error.

module store_unit_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic [3:0]  i_m,
    input  logic [31:0] i_wdata,
    output logic        o_mask_lo,
    output logic        o_mask_hi,
    output logic [7:0]  o_byte_lo,
    output logic [7:0]  o_byte_hi,
    output logic [7:0]  o_byte_rep
);
    localparam logic [1:0] L = 2'(LANE);

    logic [1:0] w_idx;
    logic       w_wrap;
    logic [7:0] w_src;

    // Source byte for this lane is (LANE - off) mod 4; lanes below off belong to the next word.
    assign w_idx  = L - i_off;
    assign w_wrap = (L < i_off);
    assign w_src  = i_wdata[{w_idx, 3'b000} +: 8];

    assign o_mask_lo = !w_wrap & i_m[w_idx];
    assign o_mask_hi =  w_wrap & i_m[w_idx];
    assign o_byte_lo = w_wrap ? 8'h00 : w_src;
    assign o_byte_hi = w_wrap ? w_src : 8'h00;

    always_comb begin
        o_byte_rep = i_wdata[8*LANE +: 8];
        case (i_size)
            2'b00:   o_byte_rep = i_wdata[7:0];
            2'b01:   o_byte_rep = i_wdata[8*(LANE%2) +: 8];
            default: o_byte_rep = i_wdata[8*LANE +: 8];
        endcase
    end
endmodule

module store_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic                  done,
    output logic                  err,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wmask
);
    localparam int NUM_LANES = 4;

`ifdef STORE_UNIT_MISALIGNED_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_size;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_err;
    logic                  r_split;

    logic                  w_accept;
    logic                  w_in_legal;
    logic                  w_in_misal;
    logic                  w_in_reject;
    logic                  w_in_split;
    logic [3:0]            w_m;
    logic [ADDR_WIDTH-1:0] w_base;

    logic [NUM_LANES-1:0]       w_mask_lo;
    logic [NUM_LANES-1:0]       w_mask_hi;
    logic [NUM_LANES-1:0][7:0]  w_byte_lo;
    logic [NUM_LANES-1:0][7:0]  w_byte_hi;
    logic [NUM_LANES-1:0][7:0]  w_byte_rep;

    // Classification is done once at accept so the beat states only look at registered flags.
    assign w_accept    = req_valid && (r_state == IDLE);
    assign w_in_legal  = !funct3[2] && (funct3[1:0] != 2'b11);
    assign w_in_misal  = ((funct3[1:0] == 2'b01) && (addr[1:0] == 2'b11)) ||
                         ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    assign w_in_reject = !w_in_legal || (w_in_misal && !SPLIT_EN);
    assign w_in_split  = w_in_legal && w_in_misal && SPLIT_EN;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_size  <= 2'b00;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_err   <= 1'b0;
            r_split <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_size  <= funct3[1:0];
                r_addr  <= addr;
                r_wdata <= wdata;
                r_err   <= w_in_reject;
                r_split <= w_in_split;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (req_valid) w_next = w_in_reject ? RESP : BEAT0;
            BEAT0: if (mem_ready) w_next = r_split ? BEAT1 : RESP;
            BEAT1: if (mem_ready) w_next = RESP;
            RESP:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_m = 4'b1111;
        case (r_size)
            2'b00:   w_m = 4'b0001;
            2'b01:   w_m = 4'b0011;
            default: w_m = 4'b1111;
        endcase
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        store_unit_lane #(.LANE(g)) u_lane (
            .i_off      (r_addr[1:0]),
            .i_size     (r_size),
            .i_m        (w_m),
            .i_wdata    (r_wdata),
            .o_mask_lo  (w_mask_lo[g]),
            .o_mask_hi  (w_mask_hi[g]),
            .o_byte_lo  (w_byte_lo[g]),
            .o_byte_hi  (w_byte_hi[g]),
            .o_byte_rep (w_byte_rep[g])
        );
    end

    assign w_base = {r_addr[ADDR_WIDTH-1:2], 2'b00};

    // Bus outputs decode straight from registered state, so they hold through stalls and drop on reset.
    always_comb begin
        req_ready = (r_state == IDLE);
        done      = 1'b0;
        err       = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        mem_wmask = 4'h0;
        case (r_state)
            BEAT0: begin
                mem_valid = 1'b1;
                mem_addr  = w_base;
                mem_wmask = w_mask_lo;
                mem_wdata = r_split ? w_byte_lo : w_byte_rep;
            end
            BEAT1: begin
                mem_valid = 1'b1;
                mem_addr  = w_base + ADDR_WIDTH'(4);
                mem_wmask = w_mask_hi;
                mem_wdata = w_byte_hi;
            end
            RESP: begin
                done = !r_err;
                err  = r_err;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: directed spec cases plus random stores against a lane-arithmetic reference model.
// Honours `STORE_UNIT_MISALIGNED_SPLIT_EN the same way as the design.
module tb_store_unit;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        done, err, mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    store_unit #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .funct3(funct3), .addr(addr), .wdata(wdata), .done(done), .err(err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one store and follow it cycle by cycle; every beat is held for 'stall' cycles before mem_ready.
    task automatic run_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input int stall);
        logic [3:0]  m;
        logic [1:0]  off;
        logic [7:0]  m8;
        logic [63:0] d64;
        logic [31:0] d;
        logic        legal, misal, rej;
        int          nb;
        logic [31:0] ea [2];
        logic [3:0]  em [2];
        logic [31:0] ed [2];
        off = a[1:0];
        case (f3)
            3'd0:    begin m = 4'b0001; d = {4{wd[7:0]}};  end
            3'd1:    begin m = 4'b0011; d = {2{wd[15:0]}}; end
            default: begin m = 4'b1111; d = wd;            end
        endcase
        m8    = {4'b0000, m} << off;
        d64   = {32'h0, wd} << (8 * off);
        legal = (f3 < 3'd3);
        misal = legal && ((f3 == 3'd1 && off == 2'd3) || (f3 == 3'd2 && off != 2'd0));
`ifdef STORE_UNIT_MISALIGNED_SPLIT_EN
        rej = !legal;
`else
        rej = !legal || misal;
`endif
        nb    = rej ? 0 : (misal ? 2 : 1);
        ea[0] = a & 32'hFFFF_FFFC;
        ea[1] = ea[0] + 32'd4;
        em[0] = m8[3:0];
        em[1] = m8[7:4];
        ed[0] = misal ? d64[31:0] : d;
        ed[1] = d64[63:32];

        chk("idle_req_ready", req_ready, 1);
        req_valid = 1'b1; funct3 = f3; addr = a; wdata = wd;
        mem_ready = 1'($urandom);
        @(negedge clk);
        req_valid = 1'b0; funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k <= stall; k++) begin
                chk("beat_valid", mem_valid, 1);
                chk("beat_addr", mem_addr, ea[b]);
                chk("beat_mask", mem_wmask, em[b]);
                chk("beat_data", mem_wdata, ed[b]);
                chk("beat_quiet", {done, err, req_ready}, 0);
                mem_ready = (k == stall);
                @(negedge clk);
            end
        end
        mem_ready = 1'($urandom);
        chk("resp_done", done, !rej);
        chk("resp_err", err, rej);
        chk("resp_no_bus", mem_valid, 0);
        chk("resp_busy", req_ready, 0);
        @(negedge clk);
        mem_ready = 1'b0;
        chk("after_pulse", {done, err}, 0);
    endtask

    initial begin
        #3;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_pulses", {done, err, mem_valid}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data_mask", {mem_wdata, mem_wmask}, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        run_store(3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 0);
        run_store(3'd0, 32'h0000_0203, 32'h0000_00A5, 0);
        run_store(3'd1, 32'h0000_0202, 32'h0000_1234, 0);
        run_store(3'd2, 32'h0000_0101, 32'h1122_3344, 3);
        run_store(3'd3, 32'h0000_0055, 32'hCAFE_F00D, 0);
        run_store(3'd2, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 1);
        run_store(3'd1, 32'hFFFF_FFFF, 32'h0000_BEEF, 2);

        for (int i = 0; i < 300; i++) begin
            logic [2:0] f3;
            f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            run_store(f3, $urandom, $urandom, $urandom_range(0, 3));
        end

        // Reset mid-beat with mem_ready low: the beat must vanish immediately.
        req_valid = 1'b1; funct3 = 3'd2; addr = 32'hFFFF_FFFE; wdata = 32'h5566_7788;
        @(negedge clk);
        req_valid = 1'b0;
`ifdef STORE_UNIT_MISALIGNED_SPLIT_EN
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("wrap_beat1_addr", mem_addr, 32'h0000_0000);
        chk("wrap_beat1_mask", mem_wmask, 4'b0011);
`else
        mem_ready = 1'b0;
        chk("misal_no_beat", {mem_valid, err}, 2'b01);
        @(negedge clk);
        req_valid = 1'b1; funct3 = 3'd2; addr = 32'h0000_0300; wdata = 32'h5566_7788;
        @(negedge clk);
        req_valid = 1'b0;
`endif
        chk("pre_reset_valid", mem_valid, 1);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_valid", mem_valid, 0);
        chk("midrst_ready", req_ready, 1);
        chk("midrst_bus", {mem_addr, mem_wdata, mem_wmask}, 0);
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("postrst_ready", req_ready, 1);
            chk("postrst_quiet", {done, err, mem_valid}, 0);
        end
        run_store(3'd0, 32'h0000_0001, 32'h0000_007E, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
